irq_controller: RTL and testbench

//  Collects NUM_SRC peripheral interrupt lines, latches and masks them, and picks one by fixed priority.

---
 rtl/irq_controller.sv | 136 +++++++++++++
 tb/tb_irq_controller.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// Fixed-priority interrupt controller: latches and masks sources and runs one handler at a time.
// Define IRQ_EDGE_EN for sticky rising-edge capture; the default build captures level-sensitively.
module irq_controller #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic               pend_clr_we,
  input  logic [NUM_SRC-1:0] pend_clr,
  input  logic               ker,
  input  logic               irq_ack,
  input  logic               eoi,
  output logic               IRQ,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] mask_q,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t             state_r;
  logic [NUM_SRC-1:0] elig_s;
  logic [NUM_SRC-1:0] pend_nxt_s;
  logic [ID_W-1:0]    winner_s;

  // Lowest set index wins; index 0 is the highest priority.
  function automatic logic [ID_W-1:0] first_set(input logic [NUM_SRC-1:0] v);
    logic [ID_W-1:0] idx;
    idx = {ID_W{1'b0}};
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = ID_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  assign elig_s   = pending & mask_q;
  assign winner_s = first_set(elig_s);

`ifdef IRQ_EDGE_EN
  logic [NUM_SRC-1:0] src_q_r;
  logic [NUM_SRC-1:0] set_s;
  logic [NUM_SRC-1:0] clr_s;
  logic [NUM_SRC-1:0] ack_vec_s;

  // Previous-cycle copy of the sources for rising-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_q_r <= {NUM_SRC{1'b0}};
    end else begin
      src_q_r <= irq_src;
    end
  end

  // A new edge always beats a same-cycle clear, so no event is lost.
  assign set_s      = irq_src & ~src_q_r;
  assign ack_vec_s  = {{(NUM_SRC-1){1'b0}}, (state_r == REQ) && irq_ack} << irq_id;
  assign clr_s      = (pend_clr_we ? pend_clr : {NUM_SRC{1'b0}}) | ack_vec_s;
  assign pend_nxt_s = set_s | (pending & ~clr_s);
`else
  logic unused_clr_s;

  // Level mode mirrors the lines; only the source itself can retire a request.
  assign pend_nxt_s   = irq_src;
  assign unused_clr_s = ^{pend_clr_we, pend_clr};
`endif

  // Pending/mask registers and the request/service FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      IRQ     <= 1'b0;
      busy    <= 1'b0;
      irq_id  <= {ID_W{1'b0}};
      pending <= {NUM_SRC{1'b0}};
      mask_q  <= {NUM_SRC{1'b0}};
    end else begin
      pending <= pend_nxt_s;
      if (mask_we) begin
        mask_q <= mask_wdata;
      end else begin
        mask_q <= mask_q;
      end
      case (state_r)
        IDLE: begin
          if ((|elig_s) && !ker) begin
            state_r <= REQ;
            IRQ     <= 1'b1;
            irq_id  <= winner_s;
          end else begin
            state_r <= IDLE;
          end
        end
        REQ: begin
          // irq_id stays frozen here; ack takes precedence over a withdrawn request.
          if (irq_ack) begin
            state_r <= SERVICE;
            IRQ     <= 1'b0;
            busy    <= 1'b1;
          end else if (!elig_s[irq_id]) begin
            state_r <= IDLE;
            IRQ     <= 1'b0;
          end else begin
            state_r <= REQ;
          end
        end
        SERVICE: begin
          if (eoi) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else begin
            state_r <= SERVICE;
          end
        end
        default: begin
          state_r <= IDLE;
          IRQ     <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a behavioural model. Works with or without IRQ_EDGE_EN.
module tb_irq_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq_src;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic       pend_clr_we;
  logic [3:0] pend_clr;
  logic       ker;
  logic       irq_ack;
  logic       eoi;
  logic       IRQ;
  logic [1:0] irq_id;
  logic [3:0] pending;
  logic [3:0] mask_q;
  logic       busy;

  irq_controller #(.NUM_SRC(4), .ID_W(2)) dut (
    .clk(clk), .reset(reset), .irq_src(irq_src), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .pend_clr_we(pend_clr_we), .pend_clr(pend_clr), .ker(ker), .irq_ack(irq_ack), .eoi(eoi),
    .IRQ(IRQ), .irq_id(irq_id), .pending(pending), .mask_q(mask_q), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: phase 0 waiting, 1 offering, 2 handler running.
  int         m_phase = 0;
  int         m_id    = 0;
  logic [3:0] m_pend  = 4'd0;
  logic [3:0] m_mask  = 4'd0;
  logic [3:0] m_prev  = 4'd0;
  logic [3:0] t_elig;
  logic [3:0] t_np;
  int         t_win;

  always @(posedge clk) begin
    if (reset) begin
      m_phase <= 0;
      m_id    <= 0;
      m_pend  <= 4'd0;
      m_mask  <= 4'd0;
      m_prev  <= 4'd0;
    end else begin
      t_elig = m_pend & m_mask;
      t_win  = -1;
      for (int i = 3; i >= 0; i--) if (t_elig[i]) t_win = i;
`ifdef IRQ_EDGE_EN
      for (int i = 0; i < 4; i++) begin
        if (irq_src[i] && !m_prev[i]) t_np[i] = 1'b1;
        else if ((pend_clr_we && pend_clr[i]) || (m_phase == 1 && irq_ack && m_id == i)) t_np[i] = 1'b0;
        else t_np[i] = m_pend[i];
      end
`else
      t_np = irq_src;
`endif
      if (m_phase == 0 && t_win >= 0 && !ker) begin
        m_phase <= 1;
        m_id    <= t_win;
      end else if (m_phase == 1 && irq_ack) begin
        m_phase <= 2;
      end else if (m_phase == 1 && !t_elig[m_id]) begin
        m_phase <= 0;
      end else if (m_phase == 2 && eoi) begin
        m_phase <= 0;
      end
      m_prev <= irq_src;
      m_pend <= t_np;
      if (mask_we) m_mask <= mask_wdata;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_IRQ", {31'd0, IRQ}, {31'd0, m_phase == 1});
      check("model_busy", {31'd0, busy}, {31'd0, m_phase == 2});
      check("model_irq_id", {30'd0, irq_id}, m_id);
      check("model_pending", {28'd0, pending}, {28'd0, m_pend});
      check("model_mask_q", {28'd0, mask_q}, {28'd0, m_mask});
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; irq_src = 4'd0; mask_we = 1'b0; mask_wdata = 4'd0; pend_clr_we = 1'b0;
    pend_clr = 4'd0; ker = 1'b0; irq_ack = 1'b0; eoi = 1'b0;
    step(1);
    chk_en = 1'b1;
    step(1);
    reset = 1'b0;
    check("rst_IRQ", {31'd0, IRQ}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pending", {28'd0, pending}, 32'd0);
    check("rst_mask", {28'd0, mask_q}, 32'd0);
    check("rst_id", {30'd0, irq_id}, 32'd0);

    mask_we = 1'b1; mask_wdata = 4'b1111;
    step(1);
    mask_we = 1'b0;
    check("mask_write", {28'd0, mask_q}, 32'hf);

    // Source 2 alone.
    irq_src = 4'b0100;
    step(1);
`ifdef IRQ_EDGE_EN
    irq_src = 4'b0000;
`endif
    check("t1_pending", {28'd0, pending}, 32'h4);
    check("t1_IRQ_early", {31'd0, IRQ}, 32'd0);
    step(1);
    check("t1_IRQ", {31'd0, IRQ}, 32'd1);
    check("t1_id", {30'd0, irq_id}, 32'd2);
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0; irq_src = 4'b0000;
    check("t1_busy", {31'd0, busy}, 32'd1);
    eoi = 1'b1;
    step(1);
    eoi = 1'b0;
    check("t1_eoi_busy", {31'd0, busy}, 32'd0);

    // Sources 3 and 1 together: 1 first, then 3 after eoi.
    irq_src = 4'b1010;
    step(1);
`ifdef IRQ_EDGE_EN
    irq_src = 4'b0000;
`endif
    step(1);
    check("t2_id", {30'd0, irq_id}, 32'd1);
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
    check("t2_busy", {31'd0, busy}, 32'd1);
`ifdef IRQ_EDGE_EN
    check("t2_pending", {28'd0, pending}, 32'h8);
`else
    check("t2_pending", {28'd0, pending}, 32'ha);
    irq_src = 4'b1000;
`endif
    eoi = 1'b1;
    step(1);
    eoi = 1'b0;
    step(1);
    check("t2_IRQ_again", {31'd0, IRQ}, 32'd1);
    check("t2_id3", {30'd0, irq_id}, 32'd3);
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0; irq_src = 4'b0000; eoi = 1'b1;
    step(1);
    eoi = 1'b0;

    // Kernel mode holds off new requests.
    ker = 1'b1; irq_src = 4'b0001;
    step(1);
`ifdef IRQ_EDGE_EN
    irq_src = 4'b0000;
`endif
    step(2);
    check("t3_ker_IRQ", {31'd0, IRQ}, 32'd0);
    ker = 1'b0;
    step(1);
    check("t3_IRQ", {31'd0, IRQ}, 32'd1);
    check("t3_id", {30'd0, irq_id}, 32'd0);
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0; irq_src = 4'b0000; eoi = 1'b1;
    step(1);
    eoi = 1'b0;

    // Masking the offered source withdraws the request but keeps it pending.
    irq_src = 4'b0100;
    step(2);
    check("t4_id", {30'd0, irq_id}, 32'd2);
    mask_we = 1'b1; mask_wdata = 4'b1011;
    step(1);
    mask_we = 1'b0;
    step(1);
    check("t4_IRQ_low", {31'd0, IRQ}, 32'd0);
    check("t4_pend2", {31'd0, pending[2]}, 32'd1);
    mask_we = 1'b1; mask_wdata = 4'b1111;
    step(1);
    mask_we = 1'b0;
    step(1);
    check("t4_rereq", {31'd0, IRQ}, 32'd1);
    check("t4_rereq_id", {30'd0, irq_id}, 32'd2);

    // Ack with a same-cycle clear and mask of the selected source still enters service.
    irq_ack = 1'b1; pend_clr_we = 1'b1; pend_clr = 4'b0100; mask_we = 1'b1; mask_wdata = 4'b1011;
    step(1);
    irq_ack = 1'b0; pend_clr_we = 1'b0; mask_we = 1'b0; irq_src = 4'b0000;
    check("t5_ack_wins", {31'd0, busy}, 32'd1);
    // Reset while busy.
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_mask", {28'd0, mask_q}, 32'd0);
    eoi = 1'b1;
    step(1);
    eoi = 1'b0;
    check("t6_eoi_noop", {31'd0, IRQ}, 32'd0);

`ifdef IRQ_EDGE_EN
    // A new edge on src 0 beats a same-cycle clear.
    mask_we = 1'b1; mask_wdata = 4'b0000;
    irq_src = 4'b0001; pend_clr_we = 1'b1; pend_clr = 4'b0001;
    step(1);
    mask_we = 1'b0; pend_clr_we = 1'b0;
    check("t5_set_beats_clr", {31'd0, pending[0]}, 32'd1);
`endif

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) irq_src = 4'($urandom);
      mask_we     = ($urandom_range(0, 7) == 0);
      mask_wdata  = 4'($urandom);
      pend_clr_we = ($urandom_range(0, 7) == 0);
      pend_clr    = 4'($urandom);
      ker         = ($urandom_range(0, 4) == 0);
      irq_ack     = ($urandom_range(0, 2) == 0);
      eoi         = ($urandom_range(0, 3) == 0);
      reset       = ($urandom_range(0, 199) == 0);
      step(1);
    end
    reset = 1'b0; irq_ack = 1'b0; eoi = 1'b0;
    step(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
